// File: rtl/aa_metrics_pkg.sv
// Shared types and constants for the approximate-adder error monitor:
// FSM encoding, LFSR polynomial and default seeds.
package aa_metrics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED_A = 32'hACE1_2345;
    localparam logic [31:0] DEF_SEED_B = 32'h1357_9BDF;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/aa_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and single-step advance.
// A zero seed would lock up the register, so it is replaced by 1.
module aa_lfsr32
    import aa_metrics_pkg::*;
#(
    parameter logic [31:0] SEED = DEF_SEED_A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] r_state;

    assign seed  = (SEED == 32'h0) ? 32'h1 : SEED;
    assign state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= seed;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

endmodule

// File: rtl/aa_err_monitor.sv
// Drives LFSR operands into an external approximate adder, compares its sum
// with the exact N-bit sum and accumulates error count, sum and max distance.
module aa_err_monitor
    import aa_metrics_pkg::*;
#(
    parameter int          N      = 16,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] SEED_A = DEF_SEED_A,
    parameter logic [31:0] SEED_B = DEF_SEED_B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_tests,
    output logic [N-1:0]       dut_a,
    output logic [N-1:0]       dut_b,
    input  logic [N-1:0]       dut_s,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   tests_run,
    output logic [CNT_W-1:0]   err_count,
    output logic [N+CNT_W-1:0] sum_ed,
    output logic [N-1:0]       max_ed
);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_num;
    logic [N-1:0]       r_dut_a, r_dut_b;
    logic [CNT_W-1:0]   r_tests_run, r_err_count;
    logic [N+CNT_W-1:0] r_sum_ed;
    logic [N-1:0]       r_max_ed;

    logic               w_accept, w_step, w_last, w_ed_nz;
    logic [CNT_W-1:0]   w_tests_inc;
    logic [N-1:0]       w_exact, w_ed;
    logic [31:0]        w_lfsr_a, w_lfsr_b, w_seed_a, w_seed_b;
    logic               w_unused;

    aa_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .step  (w_step),
        .seed  (w_seed_a),
        .state (w_lfsr_a)
    );

    aa_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .step  (w_step),
        .seed  (w_seed_b),
        .state (w_lfsr_b)
    );

    // Upper LFSR bits only feed the sequence, not the operands
    assign w_unused = ^{w_lfsr_a, w_lfsr_b, w_seed_a, w_seed_b};

    assign w_accept    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_step      = (r_state == ST_SAMPLE);
    assign w_tests_inc = r_tests_run + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last      = (w_tests_inc == r_num);

    // Exact sum wraps mod 2^N; the distance itself is non-modular
    assign w_exact = r_dut_a + r_dut_b;
    assign w_ed    = (dut_s > w_exact) ? (dut_s - w_exact) : (w_exact - dut_s);
    assign w_ed_nz = (w_ed != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next = (num_tests == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:  w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_last ? ST_DONE : ST_DRIVE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num       <= '0;
            r_dut_a     <= '0;
            r_dut_b     <= '0;
            r_tests_run <= '0;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
        end else if (w_accept) begin
            r_num       <= num_tests;
            r_tests_run <= '0;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
        end else if (r_state == ST_DRIVE) begin
            r_dut_a <= w_lfsr_a[N-1:0];
            r_dut_b <= w_lfsr_b[N-1:0];
        end else if (r_state == ST_SAMPLE) begin
            r_tests_run <= w_tests_inc;
            r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, w_ed_nz};
            r_sum_ed    <= r_sum_ed + {{CNT_W{1'b0}}, w_ed};
            if (w_ed > r_max_ed) begin
                r_max_ed <= w_ed;
            end
        end
    end

    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign tests_run = r_tests_run;
    assign err_count = r_err_count;
    assign sum_ed    = r_sum_ed;
    assign max_ed    = r_max_ed;

endmodule

// File: tb/tb_aa_err_monitor.sv
// Self-checking bench: the bench plays the approximate adder in several modes
// and checks run results against hand values and a bench-side LFSR model.
module tb_aa_err_monitor;

    localparam int          N      = 16;
    localparam int          CNT_W  = 32;
    localparam logic [31:0] SEED_A = 32'hACE1_2345;
    localparam logic [31:0] SEED_B = 32'h1357_9BDF;
    localparam logic [31:0] POLY   = 32'h8020_0003;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_tests = '0;
    logic [N-1:0]       dut_a, dut_b, dut_s;
    logic               busy, done;
    logic [CNT_W-1:0]   tests_run, err_count;
    logic [N+CNT_W-1:0] sum_ed;
    logic [N-1:0]       max_ed;

    int mode = 0;
    int checks = 0;
    int errors = 0;

    aa_err_monitor #(.N(N), .CNT_W(CNT_W), .SEED_A(SEED_A), .SEED_B(SEED_B)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tests (num_tests),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_s     (dut_s),
        .busy      (busy),
        .done      (done),
        .tests_run (tests_run),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed)
    );

    always #5 clk = ~clk;

    // 0 exact, 1 lsb flipped, 2 +0x8000, 3 lower-part-OR approximate adder (K=11)
    function automatic logic [15:0] approx(input int m, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [4:0]  hi;
        case (m)
            0: s = a + b;
            1: s = (a + b) ^ 16'h0001;
            2: s = a + b + 16'h8000;
            default: begin
                hi = a[15:11] + b[15:11] + {4'b0, a[10] & b[10]};
                s  = {hi, a[10:0] | b[10:0]};
            end
        endcase
        return s;
    endfunction

    always_comb dut_s = approx(mode, dut_a, dut_b);

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model(input int m, input int n, output logic [31:0] e_err,
                         output logic [47:0] e_sum, output logic [15:0] e_max);
        logic [31:0] sa, sb;
        logic [15:0] a, b, s, ex, ed;
        sa = SEED_A; sb = SEED_B;
        e_err = 0; e_sum = 0; e_max = 0;
        for (int i = 0; i < n; i++) begin
            a = sa[15:0]; b = sb[15:0];
            s = approx(m, a, b);
            ex = a + b;
            ed = (s > ex) ? s - ex : ex - s;
            if (ed != 0) e_err++;
            e_sum += {32'h0, ed};
            if (ed > e_max) e_max = ed;
            sa = step(sa); sb = step(sb);
        end
    endtask

    // Start a run and count edges from the accepting edge until done is seen
    task automatic run(input logic [31:0] n, input int pulse_at, output int edges,
                       output logic [15:0] first_a, output logic busy_seen);
        @(negedge clk);
        start = 1'b1; num_tests = n;
        edges = 0; first_a = '0; busy_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            edges++;
            start = (edges == pulse_at);
            if (edges == pulse_at) num_tests = 32'd5;
            if (busy) busy_seen = 1'b1;
            if (edges == 2) first_a = dut_a;
            if (done || edges > 2 * int'(n) + 20) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int          m;
        logic [31:0] n;
        logic [31:0] e_err;
        logic [47:0] e_sum;
        logic [15:0] e_max;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          edges;
        logic [15:0] fa;
        logic        bs;

        vecs[0] = '{0, 1000, 0,    48'h0,     16'h0};
        vecs[1] = '{1, 1000, 1000, 48'd1000,  16'h1};
        vecs[2] = '{2, 10,   10,   48'h50000, 16'h8000};
        vecs[3].m = 3; vecs[3].n = 3000;
        model(3, 3000, vecs[3].e_err, vecs[3].e_sum, vecs[3].e_max);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_dut_a", {48'h0, dut_a}, 64'h0);
        chk("reset_sum", {16'h0, sum_ed}, 64'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].m;
            // Mid-run start with a different count must be ignored
            run(vecs[i].n, (i == 3) ? 101 : 0, edges, fa, bs);
            chk("done_latency", 64'(edges), 64'(2 * vecs[i].n + 1));
            chk("tests_run", {32'h0, tests_run}, {32'h0, vecs[i].n});
            chk("err_count", {32'h0, err_count}, {32'h0, vecs[i].e_err});
            chk("sum_ed", {16'h0, sum_ed}, {16'h0, vecs[i].e_sum});
            chk("max_ed", {48'h0, max_ed}, {48'h0, vecs[i].e_max});
            chk("first_a", {48'h0, fa}, {48'h0, SEED_A[15:0]});
        end

        // DONE holds results across idle cycles
        repeat (4) @(posedge clk);
        #1;
        chk("hold_err", {32'h0, err_count}, {32'h0, vecs[3].e_err});
        chk("hold_done", {63'h0, done}, 64'h1);

        mode = 1;
        run(0, 0, edges, fa, bs);
        chk("zero_latency", 64'(edges), 64'd1);
        chk("zero_busy", {63'h0, bs}, 64'h0);
        chk("zero_tests", {32'h0, tests_run}, 64'h0);
        chk("zero_err", {32'h0, err_count}, 64'h0);
        chk("zero_max", {48'h0, max_ed}, 64'h0);

        // Reset 5 cycles into a run, with start held high at the reset edge
        @(negedge clk); start = 1'b1; num_tests = 100;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_tests", {32'h0, tests_run}, 64'h0);
        chk("rst_err", {32'h0, err_count}, 64'h0);
        chk("rst_sum", {16'h0, sum_ed}, 64'h0);
        chk("rst_max", {48'h0, max_ed}, 64'h0);
        chk("rst_dut_a", {48'h0, dut_a}, 64'h0);
        @(negedge clk); rst = 1'b0; start = 1'b0;

        run(4, 0, edges, fa, bs);
        chk("after_rst_latency", 64'(edges), 64'd9);
        chk("after_rst_first_a", {48'h0, fa}, {48'h0, SEED_A[15:0]});
        chk("after_rst_tests", {32'h0, tests_run}, 64'd4);
        chk("after_rst_err", {32'h0, err_count}, 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
